// File: rtl/control_mc.sv
// control_mc: multicycle CPU control FSM with instruction/data memory handshakes,
// per-opcode datapath decode and a wait-cycle timeout that traps into a sticky error state.
module control_mc #(
  parameter int TIMEOUT     = 255,
  parameter int TIMEOUT_W   = 8,
  parameter bit FAST_DECODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       eq,
  input  logic       imm_nz,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] func_alu,
  output logic       mux_alu1,
  output logic       mux_alu2,
  output logic       mux_rf,
  output logic [1:0] mux_pc,
  output logic [1:0] mux_tgt,
  output logic       we_rf,
  output logic       we_dmem,
  output logic       halted,
  output logic       timeout_err,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5, ERR = 3'd6
  } state_t;
  localparam logic [2:0] ADD = 3'd0, ADDI = 3'd1, NAND = 3'd2, LUI = 3'd3;
  localparam logic [2:0] SW = 3'd4, LW = 3'd5, BEQ = 3'd6, JALR = 3'd7;
  state_t               state_q;
  logic [2:0]           op_q, op;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_inc;
  logic                 expired, fetch, exec, mem, wb;
  // the fast variant has no DECODE cycle, so EXEC decodes the live opcode
  assign op       = (FAST_DECODE && state_q == EXEC && !rst) ? opcode : op_q;
  assign fetch    = !rst && state_q == FETCH;
  assign exec     = !rst && state_q == EXEC;
  assign mem      = !rst && state_q == MEM;
  assign wb       = !rst && state_q == WB;
  assign expired  = (TIMEOUT != 0) && (cnt_q == TIMEOUT_W'(TIMEOUT));
  assign cnt_inc  = cnt_q + TIMEOUT_W'(cnt_q != '1);
  assign func_alu = op == NAND ? 2'b01 : (op == LUI || op == JALR) ? 2'b10 : op == BEQ ? 2'b11 : 2'b00;
  assign mux_alu1 = op == LUI;
  assign mux_alu2 = op == ADDI || op == SW || op == LW;
  assign mux_rf   = op == ADD || op == NAND;
  assign mux_tgt  = op == LW ? 2'b01 : op == JALR ? 2'b10 : 2'b00;
  assign mux_pc   = op == JALR ? 2'b00 : (op == BEQ && eq) ? 2'b10 : 2'b01;
  assign imem_req = fetch;
  assign ir_we    = fetch && imem_ready;
  assign dmem_req = mem;
  assign we_dmem  = mem && op == SW;
  assign pc_we    = (exec && op == BEQ) || (mem && dmem_ready && op == SW) || wb;
  assign we_rf    = wb;
  assign halted      = state_q == HALT;
  assign timeout_err = state_q == ERR;
  assign state       = state_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= '0;
      if (state_q == (FAST_DECODE ? EXEC : DECODE)) op_q <= opcode;
      case (state_q)
        FETCH:
          if (imem_ready) state_q <= FAST_DECODE ? EXEC : DECODE;
          else if (expired) state_q <= ERR;
          else cnt_q <= cnt_inc;
        DECODE: state_q <= EXEC;
        EXEC:
          state_q <= (op == SW || op == LW) ? MEM : op == BEQ ? FETCH :
                     (op == JALR && imm_nz) ? HALT : WB;
        MEM:
          if (dmem_ready) state_q <= op == SW ? FETCH : WB;
          else if (expired) state_q <= ERR;
          else cnt_q <= cnt_inc;
        WB: state_q <= FETCH;
        default: state_q <= state_q == HALT ? HALT : ERR;
      endcase
    end
  end
endmodule

// File: tb/tb_control_mc.sv
// tb_control_mc: two control_mc instances (TIMEOUT=4 normal decode, TIMEOUT=0 fast decode)
// under shared stimulus, checked every cycle against a per-instance behavioural model.
module tb_control_mc;
  localparam logic [2:0] ADD = 3'd0, SW = 3'd4, LW = 3'd5, BEQ = 3'd6, JALR = 3'd7;
  logic       clk = 1'b0, rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       eq = 1'b0, imm_nz = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req [2], dmem_req [2], ir_we [2], pc_we [2];
  logic [1:0] func_alu [2], mux_pc [2], mux_tgt [2];
  logic       mux_alu1 [2], mux_alu2 [2], mux_rf [2];
  logic       we_rf [2], we_dmem [2], halted [2], timeout_err [2];
  logic [2:0] state [2];
  int         checks = 0, failures = 0, cyc_n = 0;
  int         ms [2], mw [2], lat [2], mc [2], pst [2];
  logic [2:0] mop [2];
  bit         prst;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    control_mc #(.TIMEOUT(g == 0 ? 4 : 0), .TIMEOUT_W(g == 0 ? 8 : 2), .FAST_DECODE(g == 1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .eq(eq), .imm_nz(imm_nz),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req[g]), .dmem_req(dmem_req[g]), .ir_we(ir_we[g]), .pc_we(pc_we[g]),
      .func_alu(func_alu[g]), .mux_alu1(mux_alu1[g]), .mux_alu2(mux_alu2[g]), .mux_rf(mux_rf[g]),
      .mux_pc(mux_pc[g]), .mux_tgt(mux_tgt[g]), .we_rf(we_rf[g]), .we_dmem(we_dmem[g]),
      .halted(halted[g]), .timeout_err(timeout_err[g]), .state(state[g])
    );
  end

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [6:0] dec(input logic [2:0] o);
    case (o)
      3'd0: return 7'b00_0_0_1_00;
      3'd1: return 7'b00_0_1_0_00;
      3'd2: return 7'b01_0_0_1_00;
      3'd3: return 7'b10_1_0_0_00;
      3'd4: return 7'b00_0_1_0_00;
      3'd5: return 7'b00_0_1_0_01;
      3'd6: return 7'b11_0_0_0_00;
      default: return 7'b10_0_0_0_10;
    endcase
  endfunction

  function automatic logic [19:0] dut_vec(input int k);
    return {imem_req[k], dmem_req[k], ir_we[k], pc_we[k], func_alu[k], mux_alu1[k], mux_alu2[k],
            mux_rf[k], mux_pc[k], mux_tgt[k], we_rf[k], we_dmem[k], halted[k], timeout_err[k], state[k]};
  endfunction

  function automatic logic [19:0] exp_vec(input int k);
    logic [2:0] o;
    logic [6:0] d;
    logic [1:0] pc;
    int s;
    s  = ms[k];
    o  = (k == 1 && s == 2 && !rst) ? opcode : mop[k];
    d  = dec(o);
    pc = o == 3'd7 ? 2'd0 : (o == 3'd6 && eq) ? 2'd2 : 2'd1;
    return {!rst && s == 0, !rst && s == 3, !rst && s == 0 && imem_ready,
            !rst && ((s == 2 && o == 3'd6) || (s == 3 && dmem_ready && o == 3'd4) || s == 4),
            d[6:2], pc, d[1:0], !rst && s == 4, !rst && s == 3 && o == 3'd4, s == 5, s == 6, 3'(s)};
  endfunction

  function automatic int base_lat(input logic [2:0] o, input int k);
    return (o == 3'd6 ? 2 : o == 3'd5 ? 4 : 3) - (k == 1 ? 1 : 0);
  endfunction

  task automatic step(input int k);
    logic [2:0] o;
    int to;
    to = k == 1 ? 0 : 4;
    o  = (k == 1 && ms[k] == 2) ? opcode : mop[k];
    if (rst) begin
      ms[k] = 0; mop[k] = 3'd0; mw[k] = 0;
    end else begin
      case (ms[k])
        0: if (imem_ready) begin ms[k] = k == 1 ? 2 : 1; mw[k] = 0; end
           else if (to > 0 && mw[k] == to) ms[k] = 6;
           else mw[k]++;
        1: begin mop[k] = opcode; ms[k] = 2; end
        2: begin
             if (k == 1) mop[k] = opcode;
             mw[k] = 0;
             ms[k] = (o == 3'd4 || o == 3'd5) ? 3 : o == 3'd6 ? 0 : (o == 3'd7 && imm_nz) ? 5 : 4;
           end
        3: if (dmem_ready) begin ms[k] = o == 3'd4 ? 0 : 4; mw[k] = 0; end
           else if (to > 0 && mw[k] == to) ms[k] = 6;
           else mw[k]++;
        4: ms[k] = 0;
        default: ;
      endcase
    end
  endtask

  task automatic eval();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d_outputs@%0d", k, cyc_n), 32'(dut_vec(k)), 32'(exp_vec(k)));
      if (!prst && pst[k] != 0 && state[k] == 3'd0)
        chk($sformatf("u%0d_latency@%0d", k, cyc_n), lat[k],
            base_lat(mop[k], k) + (mc[k] > 0 ? mc[k] - 1 : 0));
      if (state[k] == 3'd0) begin lat[k] = 0; mc[k] = 0; end
      else begin lat[k]++; if (state[k] == 3'd3) mc[k]++; end
      pst[k] = int'(state[k]);
    end
    for (int k = 0; k < 2; k++) step(k);
    prst = rst;
    cyc_n++;
  endtask

  task automatic cyc(input logic r, input logic [2:0] op, input logic ir, input logic dr,
                     input logic e, input logic inz);
    @(negedge clk);
    rst = r; opcode = op; imem_ready = ir; dmem_ready = dr; eq = e; imm_nz = inz;
    eval();
  endtask

  task automatic rstc();
    cyc(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin ms[k] = 0; mw[k] = 0; mop[k] = 3'd0; lat[k] = 0; mc[k] = 0; pst[k] = 0; end
    prst = 1'b1;
    rstc();
    chk("rst_state", 32'(state[0]), 0);
    chk("rst_imem_req", 32'(imem_req[0]), 0);
    cyc(1'b0, ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("add_c1_ir_we", 32'(ir_we[0]), 1);
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_c3_exec", 32'(state[0]), 2);
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_c4_wb", 32'(state[0]), 4);
    chk("add_c4_we_rf", 32'(we_rf[0]), 1);
    chk("add_c4_pc_we", 32'(pc_we[0]), 1);
    chk("add_c4_mux_rf", 32'(mux_rf[0]), 1);
    chk("add_c4_mux_pc", 32'(mux_pc[0]), 1);
    rstc();
    cyc(1'b0, LW, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, LW, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, LW, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, LW, 1'b0, i == 4, 1'b0, 1'b0);
      chk($sformatf("lw_dmem_req_%0d", i), 32'(dmem_req[0]), 1);
      chk($sformatf("lw_we_dmem_%0d", i), 32'(we_dmem[0]), 0);
    end
    cyc(1'b0, LW, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lw_wb_state", 32'(state[0]), 4);
    chk("lw_wb_mux_tgt", 32'(mux_tgt[0]), 1);
    chk("lw_wb_we_rf", 32'(we_rf[0]), 1);
    rstc();
    cyc(1'b0, BEQ, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, BEQ, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, BEQ, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("beq_t_pc_we", 32'(pc_we[0]), 1);
    chk("beq_t_mux_pc", 32'(mux_pc[0]), 2);
    chk("beq_t_func_alu", 32'(func_alu[0]), 3);
    chk("beq_t_we_rf", 32'(we_rf[0]), 0);
    cyc(1'b0, BEQ, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("beq_back_fetch", 32'(state[0]), 0);
    cyc(1'b0, BEQ, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, BEQ, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("beq_nt_mux_pc", 32'(mux_pc[0]), 1);
    rstc();
    cyc(1'b0, JALR, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, JALR, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, JALR, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("jalr_no_rf_write", 32'(we_rf[0]), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, JALR, 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("halt_state_%0d", i), 32'(state[0]), 5);
      chk($sformatf("halt_halted_%0d", i), 32'(halted[0]), 1);
      chk($sformatf("halt_ir_we_%0d", i), 32'(ir_we[0]), 0);
    end
    rstc();
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt_cleared", 32'(halted[0]), 0);
    rstc();
    cyc(1'b0, SW, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, SW, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("to_mem_%0d", i), 32'(state[0]), 3);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, SW, 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("to_err_state_%0d", i), 32'(state[0]), 6);
      chk($sformatf("to_err_flag_%0d", i), 32'(timeout_err[0]), 1);
      chk($sformatf("to_err_dmem_req_%0d", i), 32'(dmem_req[0]), 0);
    end
    rstc();
    cyc(1'b0, SW, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, SW, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("to_edge_pc_we", 32'(pc_we[0]), 1);
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_edge_fetch", 32'(state[0]), 0);
    chk("to_edge_no_err", 32'(timeout_err[0]), 0);
    rstc();
    cyc(1'b0, SW, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstmem_we_dmem_before", 32'(we_dmem[0]), 1);
    cyc(1'b1, SW, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rstmem_we_dmem", 32'(we_dmem[0]), 0);
    chk("rstmem_pc_we", 32'(pc_we[0]), 0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstmem_fetch", 32'(state[0]), 0);
    repeat (4000)
      cyc($urandom_range(0, 59) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_mc.md
CONTROL_MC -- requirements
Module: control_mc

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: memory-wait cycles before error; 0 disables the timeout.
REQ-002 SHALL have parameter TIMEOUT_W, default 8: wait-counter width; TIMEOUT SHALL be less than 2^TIMEOUT_W.
REQ-003 SHALL have parameter FAST_DECODE, default 0: 1 skips the DECODE state.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 opcode  in  3  instruction opcode from IR; sampled only in the op_q load cycle.
REQ-007 eq  in  1  register compare result; sampled in EXEC.
REQ-008 imm_nz  in  1  JALR immediate nonzero (halt request); sampled in EXEC.
REQ-009 imem_ready / dmem_ready  in  1 each  memory completion strobes.
REQ-010 imem_req / dmem_req  out  1 each  memory request, held until the matching ready.
REQ-011 ir_we, pc_we  out  1 each  IR / PC load strobes.
REQ-012 func_alu 2, mux_alu1 1, mux_alu2 1, mux_rf 1, mux_pc 2, mux_tgt 2  out  datapath selects.
REQ-013 we_rf, we_dmem  out  1 each  register-file / data-memory write enables.
REQ-014 halted, timeout_err  out  1 each  sticky status; state  out  3  current state encoding.

Function
REQ-015 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6; encoding 7 SHALL go to ERR.
REQ-016 FETCH: imem_req=1; on imem_ready, ir_we=1 and next state DECODE (EXEC if FAST_DECODE=1).
REQ-017 op_q SHALL load opcode in the DECODE cycle (FAST_DECODE=1: in the first EXEC cycle, with decode driven from opcode directly that cycle).
REQ-018 Decode of op_q as (func_alu, alu1, alu2, rf, tgt): 000 ADD (00,0,0,1,00); 001 ADDI (00,0,1,0,00); 010 NAND (01,0,0,1,00); 011 LUI (10,1,0,0,00); 100 SW (00,0,1,0,00); 101 LW (00,0,1,0,01); 110 BEQ (11,0,0,0,00); 111 JALR (10,0,0,0,10).
REQ-019 mux_pc SHALL be 01 (PC+1) except BEQ with eq=1 -> 10 (branch target), and JALR -> 00 (register).
REQ-020 EXEC, one cycle: SW/LW -> MEM; BEQ -> pc_we=1, then FETCH; JALR with imm_nz=1 -> HALT, no writes; otherwise -> WB.
REQ-021 MEM: dmem_req=1, and we_dmem=1 for SW; on dmem_ready, SW -> pc_we=1, then FETCH; LW -> WB.
REQ-022 WB, one cycle: we_rf=1 and pc_we=1, then FETCH.
REQ-023 we_rf, we_dmem, pc_we, ir_we, imem_req and dmem_req SHALL be 0 outside the states and conditions named above.
REQ-024 Wait counter SHALL clear on entry to FETCH/MEM and on ready, and increment each waiting cycle, saturating at 2^TIMEOUT_W-1.
REQ-025 With TIMEOUT>0, a count of TIMEOUT without ready SHALL move the FSM to ERR next cycle.
REQ-026 A ready arriving in the same cycle the count reaches TIMEOUT SHALL win, with no error.
REQ-027 ERR SHALL set timeout_err=1 with all strobes 0, and hold until rst.
REQ-028 HALT SHALL set halted=1 with all strobes 0, and hold until rst; ready inputs SHALL be ignored there.
REQ-029 Ready strobes outside their request state SHALL be ignored.
REQ-030 Every instruction's latency from FETCH exit is: BEQ 2, ALU/LUI/JALR 3, SW 3+dmem wait, LW 4+dmem wait; each is one less with FAST_DECODE=1.

Reset
REQ-031 rst=1 SHALL force state=FETCH, op_q=000, wait counter 0, halted=0, timeout_err=0 at the next edge.
REQ-032 While rst=1, all strobes and requests SHALL be driven 0; selects SHALL reflect op_q.
REQ-033 Reset mid-instruction SHALL abandon it with no further write; a pending ready SHALL be ignored.

Verification
REQ-034 ADD with imem_ready on first FETCH cycle -> ir_we cycle 1, EXEC cycle 3, WB cycle 4 with we_rf=1, pc_we=1, mux_rf=1, mux_pc=01.
REQ-035 LW, dmem_ready after 3 wait cycles -> dmem_req high 4 cycles, then WB with mux_tgt=01, we_rf=1; we_dmem stays 0.
REQ-036 BEQ with eq=1 -> pc_we=1, mux_pc=10, func_alu=11 in EXEC; we_rf=0. With eq=0 -> mux_pc=01.
REQ-037 JALR with imm_nz=1 -> HALT, halted=1; later imem_ready pulses give no strobes until rst.
REQ-038 TIMEOUT=4 with no dmem_ready on SW -> ERR after 4 wait cycles, timeout_err=1; ready on the 4th count instead -> FETCH, no error.
REQ-039 rst asserted in MEM of SW -> state=FETCH next edge, we_dmem=0 from the rst cycle.
